// File: rtl/ecc_pkg.sv
// Shared ECC datapath definitions: field width and the division-engine state encoding.
package ecc_pkg;

    localparam int WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mod_half_sub.sv
// Combinational field helpers for one x-register pair:
//   half = x/2 mod mr  (add mr first when x is odd so the halving is exact)
//   diff = x-y mod mr  (fold back by mr when the raw subtraction borrows)
// Both results stay in [0, mr) as long as x and y are already in that range.
module mod_half_sub #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] mr,
    output logic [WIDTH-1:0] half,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH:0] sum;

    // Halving: one extra bit keeps the carry of x+mr before the shift.
    always_comb begin
        sum  = {1'b0, x} + (x[0] ? {1'b0, mr} : '0);
        half = sum[WIDTH:1];
    end

    // Subtraction: a wrapped x-y plus mr lands back in range modulo 2^WIDTH.
    always_comb begin
        diff = (x - y) + ((x < y) ? mr : '0);
    end

endmodule

// File: rtl/modular_inversion.sv
// Kaliski-style binary extended-Euclid divider: c = b * a^-1 mod m.
// One algorithm step per clock; start/ready handshake with a level ready.
module modular_inversion
    import ecc_pkg::*;
#(
    parameter int WIDTH = ecc_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] c,
    output logic             ready
);

    state_t state, state_nxt;

    logic [WIDTH-1:0] u, v, x1, x2, mr;
    logic [WIDTH-1:0] x1_half, x1_diff, x2_half, x2_diff;
    logic             u_one, v_one, degen, term;

    // x1 side: halve x1, or x1-x2
    mod_half_sub #(.WIDTH(WIDTH)) u_x1_ops (
        .x    (x1),
        .y    (x2),
        .mr   (mr),
        .half (x1_half),
        .diff (x1_diff)
    );

    // x2 side: halve x2, or x2-x1
    mod_half_sub #(.WIDTH(WIDTH)) u_x2_ops (
        .x    (x2),
        .y    (x1),
        .mr   (mr),
        .half (x2_half),
        .diff (x2_diff)
    );

    // Termination tests; u or v reaching 0 means gcd(a,m) != 1 (or a was 0).
    always_comb begin
        u_one = (u == WIDTH'(1));
        v_one = (v == WIDTH'(1));
        degen = (u == '0) || (v == '0);
        term  = u_one || v_one || degen;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; DONE waits for start to drop so one request yields one result.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (term)  state_nxt = DONE;
            DONE: begin
                ready = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Working registers and result: load on accept, one reduction step per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u  <= '0;
            v  <= '0;
            x1 <= '0;
            x2 <= '0;
            mr <= '0;
            c  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        u  <= a;
                        v  <= m;
                        x1 <= b;
                        x2 <= '0;
                        mr <= m;
                    end
                end
                RUN: begin
                    if (u_one)          c <= x1;
                    else if (v_one)     c <= x2;
                    else if (degen)     c <= '0;
                    else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= x1_half;
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= x2_half;
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= x1_diff;
                    end else begin
                        v  <= v - u;
                        x2 <= x2_diff;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_modular_inversion.sv
// Directed bench for modular_inversion with hand-computed results.
module tb_modular_inversion;
    import ecc_pkg::*;

    localparam int W      = ecc_pkg::WIDTH;
    localparam int BUDGET = 4 * W + 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, m;
    logic [W-1:0] c;
    logic         ready;

    int checks;
    int failures;

    localparam logic [W-1:0] P256K1 =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [W-1:0] P256K1_HALF1 =
        256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18;

    modular_inversion #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .c     (c),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present operands with start high, wait for ready; start is left high.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] tm, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        @(negedge clk);
        a = ta; b = tb_; m = tm; start = 1'b1;
        for (int i = 0; i < BUDGET + 4; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        bit ok;
        checks = 0; failures = 0;
        start = 1'b0; a = '0; b = '0; m = '0;
        rst_n = 1'b0;
        #20;
        chk("rst_ready", W'(ready), W'(0));
        chk("rst_c", c, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: 190^-1 mod 367 = 226, stable while start held
        run_op(W'(190), W'(1), W'(367), cyc, ok);
        chk("t1_done", W'(ok), W'(1));
        chk("t1_lat", W'(cyc <= BUDGET), W'(1));
        chk("t1_c", c, W'(226));
        repeat (5) @(negedge clk);
        chk("t1_hold_ready", W'(ready), W'(1));
        chk("t1_hold_c", c, W'(226));
        drop_start();
        chk("t1_idle_ready", W'(ready), W'(0));
        chk("t1_idle_c", c, W'(226));

        // 2: a=1 finishes in one RUN cycle with c=b
        run_op(W'(1), W'(5), W'(367), cyc, ok);
        chk("t2_done", W'(ok), W'(1));
        chk("t2_lat", W'(cyc), W'(2));
        chk("t2_c", c, W'(5));
        drop_start();

        // 3: 4/3 mod 7 = 6, then 1/2 mod 7 = 4
        run_op(W'(3), W'(4), W'(7), cyc, ok);
        chk("t3_done", W'(ok), W'(1));
        chk("t3_c", c, W'(6));
        drop_start();
        chk("t3_idle_ready", W'(ready), W'(0));
        chk("t3_idle_c", c, W'(6));
        run_op(W'(2), W'(1), W'(7), cyc, ok);
        chk("t3b_done", W'(ok), W'(1));
        chk("t3b_c", c, W'(4));
        drop_start();

        // 4: full-width modulus, 2^-1 mod p = (p+1)/2
        run_op(W'(2), W'(1), P256K1, cyc, ok);
        chk("t4_done", W'(ok), W'(1));
        chk("t4_lat", W'(cyc <= BUDGET), W'(1));
        chk("t4_c", c, P256K1_HALF1);
        drop_start();

        // 6: asynchronous reset in the middle of a RUN
        @(negedge clk);
        a = W'(190); b = W'(1); m = W'(367); start = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        chk("t6_busy", W'(ready), W'(0));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ready", W'(ready), W'(0));
        chk("t6_rst_c", c, '0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(W'(190), W'(1), W'(367), cyc, ok);
        chk("t6_done", W'(ok), W'(1));
        chk("t6_c", c, W'(226));
        drop_start();

        // 5: gcd(6,9)=3 terminates with c=0
        run_op(W'(6), W'(1), W'(9), cyc, ok);
        chk("t5_done", W'(ok), W'(1));
        chk("t5_ready", W'(ready), W'(1));
        chk("t5_c", c, '0);
        drop_start();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
